encoder_8to3_pending: RTL

ENCODER_8TO3_PENDING -- requirements
Module: encoder_8to3_pending

---
 rtl/encoder_8to3_pending_pkg.sv | 21 ++
 rtl/encoder_8to3_pending_if.sv | 29 ++
 rtl/encoder_8to3_pending_priority_enc.sv | 25 ++
 rtl/encoder_8to3_pending.sv | 81 ++++++++
 4 files changed

// File: rtl/encoder_8to3_pending_pkg.sv
// Shared types and constants for the 8-to-3 pending-request encoder.
//   REQ_W / IDX_W : request mask width and presented-index width
//   state_t       : presentation FSM state (StIdle = nothing shown, StPresent = valid high)
//   idx_to_onehot : index-to-mask decode used when clearing an acknowledged request
package encoder_8to3_pending_pkg;

  localparam int unsigned REQ_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [0:0] state_t;
  localparam state_t StIdle    = 1'b0;
  localparam state_t StPresent = 1'b1;

  function automatic logic [REQ_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_W-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/encoder_8to3_pending_if.sv
// Request/presentation bus of the pending encoder.
//   en, in   : capture enable and request lines (driven by master)
//   ack      : consumer accepts the presented index (driven by master)
//   out      : presented index, zero while valid is low
//   valid    : out holds a pending request
//   pending  : registered sticky pending mask
//   multi    : valid and two or more requests pending
interface encoder_8to3_pending_if;
  import encoder_8to3_pending_pkg::*;

  logic             en;
  logic [REQ_W-1:0] in;
  logic             ack;
  logic [IDX_W-1:0] out;
  logic             valid;
  logic [REQ_W-1:0] pending;
  logic             multi;

  modport master (
    output en, in, ack,
    input  out, valid, pending, multi
  );

  modport slave (
    input  en, in, ack,
    output out, valid, pending, multi
  );

endinterface

// File: rtl/encoder_8to3_pending_priority_enc.sv
// Combinational highest-set-bit search over an 8-bit request mask.
//   in  : request mask, bit 7 has highest priority
//   idx : index of the highest set bit (0 when none set)
//   any : at least one bit of in is set
module priority_enc_8to3
  import encoder_8to3_pending_pkg::*;
(
  input  logic [REQ_W-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < int'(REQ_W); i++) begin
      if (in[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any = |in;

endmodule

// File: rtl/encoder_8to3_pending.sv
// Sticky 8-source request collector that presents one pending request at a time.
// Requests accumulate in a pending mask; the highest pending index is loaded into
// out and held (no preemption) until acknowledged, which clears that bit.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, overrides all other inputs
//   bus  : request/presentation interface (slave side)
module encoder_8to3_pending
  import encoder_8to3_pending_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  encoder_8to3_pending_if.slave   bus
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] out_q, out_d;
  logic [REQ_W-1:0] pending_q, pending_d;

  logic             valid;
  logic [REQ_W-1:0] set_mask;
  logic [REQ_W-1:0] clr_mask;
  logic [IDX_W-1:0] pe_idx;
  logic             pe_any;

  // Search the registered mask so new requests are presented one edge after capture.
  priority_enc_8to3 u_priority_enc (
    .in  (pending_q),
    .idx (pe_idx),
    .any (pe_any)
  );

  assign valid    = (state_q == StPresent);
  assign set_mask = bus.en ? bus.in : '0;
  assign clr_mask = (valid && bus.ack) ? idx_to_onehot(out_q) : '0;

  always_comb begin
    // Clear first, then set: a request landing on the bit being acked survives.
    pending_d = (pending_q & ~clr_mask) | set_mask;

    state_d = state_q;
    out_d   = out_q;
    case (state_q)
      StIdle: begin
        if (pe_any) begin
          state_d = StPresent;
          out_d   = pe_idx;
        end
      end
      StPresent: begin
        // Returning to idle forces at least one low-valid cycle between presentations.
        if (bus.ack) begin
          state_d = StIdle;
          out_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      out_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      pending_q <= pending_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid;
  assign bus.pending = pending_q;
  // x & (x - 1) is non-zero exactly when two or more bits are set.
  assign bus.multi   = valid && ((pending_q & (pending_q - REQ_W'(1))) != '0);

endmodule
